// File: rtl/serial_bus_master.sv
`timescale 1ns/1ps
// Serial bus master: arbitrates for a shared 1-wire bus, shifts ID/address/data LSB first, reads back data.
// Latency: start to done = 29 cycles (defaults) + grant wait + ack/start-bit wait; every output registered.
// Backpressure: stalls in ARB/WAIT_ACK/WAIT_START until grant/ack/start bit; aborts after TIMEOUT wait cycles.
module serial_bus_master #(
    parameter int ADDRESS_WIDTH = 15,
    parameter int DATA_WIDTH    = 8,
    parameter int ID_WIDTH      = 3,
    parameter int TIMEOUT       = 255
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic                     rd_wrt_in,
    input  logic [ID_WIDTH-1:0]      slave_id,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic                     arbiter_req,
    input  logic                     arbiter_grant,
    output logic                     bus_util,
    output logic                     rd_wrt,
    input  logic                     slave_busy,
    inout  wire                      data_bus_serial,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     done,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int MAX_AD     = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH : DATA_WIDTH;
    localparam int BIT_CNT_W  = $clog2(MAX_AD + 1);
    localparam int SH_W       = (MAX_AD > ID_WIDTH) ? MAX_AD : ID_WIDTH;
    localparam int WAIT_CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [3:0] {
        IDLE, ARB, SEND_ID, SEND_ADDR, SEND_DATA, WAIT_ACK, WAIT_START, RECV_DATA, FINISH
    } state_t;

    state_t                  state_q, state_d;
    logic                    dir_sh_q, dir_sh_d;
    logic [ID_WIDTH-1:0]     id_sh_q, id_sh_d;
    logic [ADDRESS_WIDTH-1:0] addr_sh_q, addr_sh_d;
    logic [DATA_WIDTH-1:0]   wdata_sh_q, wdata_sh_d;
    logic [SH_W-1:0]         tx_sh_q, tx_sh_d;
    logic [DATA_WIDTH-1:0]   rx_sh_q, rx_sh_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    arbiter_req_q, arbiter_req_d;
    logic                    bus_util_q, bus_util_d;
    logic                    rd_wrt_q, rd_wrt_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    timeout_err_q, timeout_err_d;
    logic                    abort;
    logic                    line_hi;
    logic                    drive_en;

    // The line is ours only while shifting out; the slave may drive it the very next cycle.
    assign drive_en        = (state_q == SEND_ID) || (state_q == SEND_ADDR) || (state_q == SEND_DATA);
    assign data_bus_serial = drive_en ? tx_sh_q[0] : 1'bz;
    assign line_hi         = (data_bus_serial == 1'b1);

    assign arbiter_req = arbiter_req_q;
    assign bus_util    = bus_util_q;
    assign rd_wrt      = rd_wrt_q;
    assign rdata       = rdata_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

    // Next-state and next-output computation; outputs are set on the transition into each state.
    always_comb begin
        state_d       = state_q;
        dir_sh_d      = dir_sh_q;
        id_sh_d       = id_sh_q;
        addr_sh_d     = addr_sh_q;
        wdata_sh_d    = wdata_sh_q;
        tx_sh_d       = tx_sh_q;
        rx_sh_d       = rx_sh_q;
        bit_cnt_d     = bit_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        arbiter_req_d = arbiter_req_q;
        bus_util_d    = bus_util_q;
        rd_wrt_d      = rd_wrt_q;
        rdata_d       = rdata_q;
        done_d        = 1'b0;
        busy_d        = busy_q;
        timeout_err_d = 1'b0;
        abort         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dir_sh_d      = rd_wrt_in;
                    id_sh_d       = slave_id;
                    addr_sh_d     = addr;
                    wdata_sh_d    = wdata;
                    wait_cnt_d    = '0;
                    arbiter_req_d = 1'b1;
                    busy_d        = 1'b1;
                    state_d       = ARB;
                end
            end
            ARB: begin
                if (arbiter_grant) begin
                    bit_cnt_d  = '0;
                    tx_sh_d    = SH_W'(id_sh_q);
                    bus_util_d = 1'b1;
                    rd_wrt_d   = dir_sh_q;
                    state_d    = SEND_ID;
                end else if (wait_cnt_q == WAIT_CNT_W'(TIMEOUT)) begin
                    abort = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            SEND_ID: begin
                if (bit_cnt_q == BIT_CNT_W'(ID_WIDTH - 1)) begin
                    bit_cnt_d = '0;
                    tx_sh_d   = SH_W'(addr_sh_q);
                    state_d   = SEND_ADDR;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    tx_sh_d   = tx_sh_q >> 1;
                end
            end
            SEND_ADDR: begin
                if (bit_cnt_q == BIT_CNT_W'(ADDRESS_WIDTH - 1)) begin
                    bit_cnt_d  = '0;
                    wait_cnt_d = '0;
                    if (dir_sh_q) begin
                        state_d = WAIT_START;
                    end else begin
                        tx_sh_d = SH_W'(wdata_sh_q);
                        state_d = SEND_DATA;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    tx_sh_d   = tx_sh_q >> 1;
                end
            end
            SEND_DATA: begin
                if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = WAIT_ACK;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    tx_sh_d   = tx_sh_q >> 1;
                end
            end
            WAIT_ACK: begin
                if (!slave_busy) begin
                    done_d        = 1'b1;
                    arbiter_req_d = 1'b0;
                    state_d       = FINISH;
                end else if (wait_cnt_q == WAIT_CNT_W'(TIMEOUT)) begin
                    abort = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            WAIT_START: begin
                if (line_hi) begin
                    bit_cnt_d = '0;
                    state_d   = RECV_DATA;
                end else if (wait_cnt_q == WAIT_CNT_W'(TIMEOUT)) begin
                    abort = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            RECV_DATA: begin
                rx_sh_d = {line_hi, rx_sh_q[DATA_WIDTH-1:1]};
                if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                    rdata_d       = rx_sh_d;
                    done_d        = 1'b1;
                    arbiter_req_d = 1'b0;
                    state_d       = FINISH;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            FINISH: begin
                bus_util_d = 1'b0;
                rd_wrt_d   = 1'b0;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A stalled wait gives the bus back immediately; rdata is left untouched.
        if (abort) begin
            timeout_err_d = 1'b1;
            arbiter_req_d = 1'b0;
            bus_util_d    = 1'b0;
            rd_wrt_d      = 1'b0;
            busy_d        = 1'b0;
            state_d       = IDLE;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            dir_sh_q      <= 1'b0;
            id_sh_q       <= '0;
            addr_sh_q     <= '0;
            wdata_sh_q    <= '0;
            tx_sh_q       <= '0;
            rx_sh_q       <= '0;
            bit_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            arbiter_req_q <= 1'b0;
            bus_util_q    <= 1'b0;
            rd_wrt_q      <= 1'b0;
            rdata_q       <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_sh_q      <= dir_sh_d;
            id_sh_q       <= id_sh_d;
            addr_sh_q     <= addr_sh_d;
            wdata_sh_q    <= wdata_sh_d;
            tx_sh_q       <= tx_sh_d;
            rx_sh_q       <= rx_sh_d;
            bit_cnt_q     <= bit_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            arbiter_req_q <= arbiter_req_d;
            bus_util_q    <= bus_util_d;
            rd_wrt_q      <= rd_wrt_d;
            rdata_q       <= rdata_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule
